ex_stage_muldiv: RTL and testbench

//  Next-generation execute stage: RV32I ALU/branch/jump resolution plus the RV32M multiply/divide unit.

---
 rtl/ex_stage_muldiv.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_ex_stage_muldiv.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_muldiv.sv
// Execute stage: RV32I ALU, branch/jump resolution and the RV32M multiply/divide
// unit, with valid/ready handshakes towards decode and MEM.
module ex_stage_muldiv #(
  parameter int unsigned width         = 32,
  parameter int unsigned rsWidth       = 5,
  parameter int unsigned opcodeWidth   = 7,
  parameter bit          MUL_ITERATIVE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   killIn,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [opcodeWidth-1:0] opcode,
  input  logic [2:0]             func3,
  input  logic [6:0]             func7,
  input  logic [width-1:0]       reg1Value,
  input  logic [width-1:0]       reg2Value,
  input  logic [width-1:0]       immediate,
  input  logic [width-1:0]       PC,
  input  logic [rsWidth-1:0]     rd,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   readOut,
  output logic                   writeOut,
  output logic                   noMEMOut,
  output logic [width-1:0]       valueOut,
  output logic [width-1:0]       addressOut,
  output logic [2:0]             addressModeOut,
  output logic [rsWidth-1:0]     rdOut,
  output logic                   flushOut,
  output logic [width-1:0]       flushAddrOut
);

  localparam int unsigned CW = $clog2(width + 1);
  localparam logic [opcodeWidth-1:0] OP_REG    = opcodeWidth'(7'b0110011);
  localparam logic [opcodeWidth-1:0] OP_IMM    = opcodeWidth'(7'b0010011);
  localparam logic [opcodeWidth-1:0] OP_LUI    = opcodeWidth'(7'b0110111);
  localparam logic [opcodeWidth-1:0] OP_AUIPC  = opcodeWidth'(7'b0010111);
  localparam logic [opcodeWidth-1:0] OP_JAL    = opcodeWidth'(7'b1101111);
  localparam logic [opcodeWidth-1:0] OP_JALR   = opcodeWidth'(7'b1100111);
  localparam logic [opcodeWidth-1:0] OP_BRANCH = opcodeWidth'(7'b1100011);
  localparam logic [opcodeWidth-1:0] OP_LOAD   = opcodeWidth'(7'b0000011);
  localparam logic [opcodeWidth-1:0] OP_STORE  = opcodeWidth'(7'b0100011);
  localparam logic [width-1:0]       XMIN      = {1'b1, {(width-1){1'b0}}};

  typedef enum logic {IDLE, MD_BUSY} state_e;
  state_e state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*width-1:0]   acc_q, acc_d, opa_q, opa_d;
  logic [width-1:0]     opb_q, opb_d;
  logic                 neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic [2:0]           md_f3_q, md_f3_d;
  logic [rsWidth-1:0]   md_rd_q, md_rd_d;

  logic                 out_valid_q, out_valid_d;
  logic                 read_q, read_d, write_q, write_d, nomem_q, nomem_d;
  logic [width-1:0]     value_q, value_d, addr_q, addr_d;
  logic [2:0]           amode_q, amode_d;
  logic [rsWidth-1:0]   rd_q, rd_d;
  logic                 flush_q, flush_d;
  logic [width-1:0]     flush_addr_q, flush_addr_d;

  logic                 accept, is_md, is_div, div_signed, a_signed, b_signed;
  logic                 a_neg, b_neg, div_zero, div_ovf, md_fast;
  logic [width-1:0]     mag_a, mag_b, fast_md_value;
  logic [2*width-1:0]   comb_prod, comb_prod_s;

  logic [width-1:0]     alu_b, alu_res, alu_sra, ea;
  logic [4:0]           shamt;
  logic                 taken;
  logic [width-1:0]     sc_value, sc_addr, sc_target;
  logic [rsWidth-1:0]   sc_rd;
  logic                 sc_read, sc_write, sc_nomem, sc_flush;

  logic [width:0]       div_trial;
  logic [width-1:0]     div_sub;
  logic [2*width-1:0]   acc_step, opa_step, prod_fin;
  logic [width-1:0]     opb_step, quo_fin, rem_fin, md_result;

  assign inReady = (state_q == IDLE) && (!out_valid_q || outReady);
  assign accept  = inValid && inReady && !killIn;

  // Operand conditioning for the multiply/divide unit (sign-magnitude form).
  always_comb begin
    is_md      = (opcode == OP_REG) && (func7 == 7'b0000001);
    is_div     = func3[2];
    div_signed = !func3[0];
    a_signed   = is_div ? div_signed : ((func3 == 3'd1) || (func3 == 3'd2));
    b_signed   = is_div ? div_signed : (func3 == 3'd1);
    a_neg      = a_signed && reg1Value[width-1];
    b_neg      = b_signed && reg2Value[width-1];
    mag_a      = a_neg ? -reg1Value : reg1Value;
    mag_b      = b_neg ? -reg2Value : reg2Value;
    div_zero   = (reg2Value == '0);
    div_ovf    = div_signed && (reg1Value == XMIN) && (reg2Value == '1);
    md_fast    = is_div ? (div_zero || div_ovf) : !MUL_ITERATIVE;
    comb_prod   = {{width{1'b0}}, mag_a} * {{width{1'b0}}, mag_b};
    comb_prod_s = (a_neg ^ b_neg) ? -comb_prod : comb_prod;
    if (is_div)
      fast_md_value = func3[1] ? (div_zero ? reg1Value : '0) : (div_zero ? '1 : reg1Value);
    else
      fast_md_value = (func3 == 3'd0) ? comb_prod_s[width-1:0] : comb_prod_s[2*width-1:width];
  end

  // Single-cycle ALU, branch and address computation.
  always_comb begin
    alu_b   = (opcode == OP_REG) ? reg2Value : immediate;
    shamt   = alu_b[4:0];
    ea      = reg1Value + immediate;
    alu_sra = $signed(reg1Value) >>> shamt;
    case (func3)
      3'd0:    alu_res = ((opcode == OP_REG) && func7[5]) ? reg1Value - alu_b : reg1Value + alu_b;
      3'd1:    alu_res = reg1Value << shamt;
      3'd2:    alu_res = width'($signed(reg1Value) < $signed(alu_b));
      3'd3:    alu_res = width'(reg1Value < alu_b);
      3'd4:    alu_res = reg1Value ^ alu_b;
      3'd5:    alu_res = func7[5] ? alu_sra : reg1Value >> shamt;
      3'd6:    alu_res = reg1Value | alu_b;
      default: alu_res = reg1Value & alu_b;
    endcase
    case (func3)
      3'd0:    taken = (reg1Value == reg2Value);
      3'd1:    taken = (reg1Value != reg2Value);
      3'd4:    taken = ($signed(reg1Value) < $signed(reg2Value));
      3'd5:    taken = ($signed(reg1Value) >= $signed(reg2Value));
      3'd6:    taken = (reg1Value < reg2Value);
      3'd7:    taken = (reg1Value >= reg2Value);
      default: taken = 1'b0;
    endcase
    sc_value  = '0;
    sc_addr   = '0;
    sc_target = PC + immediate;
    sc_rd     = rd;
    sc_read   = 1'b0;
    sc_write  = 1'b0;
    sc_nomem  = 1'b1;
    sc_flush  = 1'b0;
    case (opcode)
      OP_REG, OP_IMM: sc_value = is_md ? fast_md_value : alu_res;
      OP_LUI:         sc_value = immediate << 12;
      OP_AUIPC:       sc_value = PC + (immediate << 12);
      OP_JAL: begin
        sc_value = PC + width'(4);
        sc_flush = 1'b1;
      end
      OP_JALR: begin
        sc_value  = PC + width'(4);
        sc_flush  = 1'b1;
        sc_target = ea & ~width'(1);
      end
      OP_BRANCH: begin
        sc_rd    = '0;
        sc_flush = taken;
      end
      OP_LOAD: begin
        sc_read  = 1'b1;
        sc_nomem = 1'b0;
        sc_addr  = ea;
      end
      OP_STORE: begin
        sc_write = 1'b1;
        sc_nomem = 1'b0;
        sc_addr  = ea;
        sc_value = reg2Value;
        sc_rd    = '0;
      end
      default: sc_rd = '0;
    endcase
  end

  // One shift-add or restoring-divide step; the final step feeds the result
  // directly so the answer is registered on the edge the counter hits zero.
  always_comb begin
    div_trial = acc_q[2*width-1:width-1];
    div_sub   = div_trial[width-1:0] - opa_q[width-1:0];
    acc_step  = acc_q;
    opa_step  = opa_q;
    opb_step  = opb_q;
    if (!md_f3_q[2]) begin
      if (opb_q[0]) acc_step = acc_q + opa_q;
      opa_step = opa_q << 1;
      opb_step = opb_q >> 1;
    end else if (div_trial >= {1'b0, opa_q[width-1:0]}) begin
      acc_step = {div_sub, acc_q[width-2:0], 1'b1};
    end else begin
      acc_step = {acc_q[2*width-2:0], 1'b0};
    end
    prod_fin = neg_q ? -acc_step : acc_step;
    quo_fin  = neg_q ? -acc_step[width-1:0] : acc_step[width-1:0];
    rem_fin  = neg_rem_q ? -acc_step[2*width-1:width] : acc_step[2*width-1:width];
    if (!md_f3_q[2])
      md_result = (md_f3_q[1:0] == 2'd0) ? prod_fin[width-1:0] : prod_fin[2*width-1:width];
    else
      md_result = md_f3_q[1] ? rem_fin : quo_fin;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    neg_d        = neg_q;
    neg_rem_d    = neg_rem_q;
    md_f3_d      = md_f3_q;
    md_rd_d      = md_rd_q;
    out_valid_d  = out_valid_q;
    read_d       = read_q;
    write_d      = write_q;
    nomem_d      = nomem_q;
    value_d      = value_q;
    addr_d       = addr_q;
    amode_d      = amode_q;
    rd_d         = rd_q;
    flush_d      = 1'b0;
    flush_addr_d = flush_addr_q;
    if (out_valid_q && outReady) out_valid_d = 1'b0;
    if (killIn) begin
      state_d      = IDLE;
      out_valid_d  = 1'b0;
      read_d       = 1'b0;
      write_d      = 1'b0;
      nomem_d      = 1'b1;
      value_d      = '0;
      addr_d       = '0;
      amode_d      = '0;
      rd_d         = '0;
      flush_addr_d = '0;
    end else if (state_q == MD_BUSY) begin
      acc_d = acc_step;
      opa_d = opa_step;
      opb_d = opb_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        value_d     = md_result;
        rd_d        = md_rd_q;
        nomem_d     = 1'b1;
        read_d      = 1'b0;
        write_d     = 1'b0;
        addr_d      = '0;
        amode_d     = md_f3_q;
      end
    end else if (accept) begin
      if (is_md && !md_fast) begin
        state_d   = MD_BUSY;
        cnt_d     = CW'(width);
        acc_d     = is_div ? {{width{1'b0}}, mag_a} : '0;
        opa_d     = is_div ? {{width{1'b0}}, mag_b} : {{width{1'b0}}, mag_a};
        opb_d     = mag_b;
        neg_d     = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        md_f3_d   = func3;
        md_rd_d   = rd;
      end else begin
        out_valid_d = 1'b1;
        value_d     = sc_value;
        addr_d      = sc_addr;
        amode_d     = func3;
        rd_d        = sc_rd;
        read_d      = sc_read;
        write_d     = sc_write;
        nomem_d     = sc_nomem;
        flush_d     = sc_flush;
        if (sc_flush) flush_addr_d = sc_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      neg_q        <= 1'b0;
      neg_rem_q    <= 1'b0;
      md_f3_q      <= '0;
      md_rd_q      <= '0;
      out_valid_q  <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      nomem_q      <= 1'b1;
      value_q      <= '0;
      addr_q       <= '0;
      amode_q      <= '0;
      rd_q         <= '0;
      flush_q      <= 1'b0;
      flush_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      neg_q        <= neg_d;
      neg_rem_q    <= neg_rem_d;
      md_f3_q      <= md_f3_d;
      md_rd_q      <= md_rd_d;
      out_valid_q  <= out_valid_d;
      read_q       <= read_d;
      write_q      <= write_d;
      nomem_q      <= nomem_d;
      value_q      <= value_d;
      addr_q       <= addr_d;
      amode_q      <= amode_d;
      rd_q         <= rd_d;
      flush_q      <= flush_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  assign outValid       = out_valid_q;
  assign readOut        = read_q;
  assign writeOut       = write_q;
  assign noMEMOut       = nomem_q;
  assign valueOut       = value_q;
  assign addressOut     = addr_q;
  assign addressModeOut = amode_q;
  assign rdOut          = rd_q;
  assign flushOut       = flush_q;
  assign flushAddrOut   = flush_addr_q;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboard bench for ex_stage_muldiv: a reference model predicts each accepted
// instruction's result; the monitor compares at every output handshake.
module tb_ex_stage_muldiv;

  localparam logic [6:0] OPREG = 7'b0110011, OPIMM = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] MD7 = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst, killIn, inValid, inReady, outValid, outReady;
  logic        readOut, writeOut, noMEMOut, flushOut;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3, addressModeOut;
  logic [31:0] reg1Value, reg2Value, immediate, PC, valueOut, addressOut, flushAddrOut;
  logic [4:0]  rd, rdOut;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  ex_stage_muldiv #(.width(32), .rsWidth(5), .opcodeWidth(7), .MUL_ITERATIVE(1'b1)) dut (
    .clk(clk), .rst(rst), .killIn(killIn), .inValid(inValid), .inReady(inReady),
    .opcode(opcode), .func3(func3), .func7(func7), .reg1Value(reg1Value),
    .reg2Value(reg2Value), .immediate(immediate), .PC(PC), .rd(rd),
    .outValid(outValid), .outReady(outReady), .readOut(readOut), .writeOut(writeOut),
    .noMEMOut(noMEMOut), .valueOut(valueOut), .addressOut(addressOut),
    .addressModeOut(addressModeOut), .rdOut(rdOut), .flushOut(flushOut),
    .flushAddrOut(flushAddrOut)
  );

  typedef struct {
    logic [31:0] value;
    logic [31:0] addr;
    logic [31:0] target;
    logic [4:0]  rd;
    logic [2:0]  amode;
    logic        rd_en;
    logic        wr_en;
    logic        nomem;
    logic        flush;
    logic        chk_val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] r);
    exp_t e;
    logic [31:0] y;
    longint p;
    logic [63:0] pu;
    int sa, sb;
    e.value = '0; e.addr = '0; e.target = pc + imm; e.rd = r; e.amode = f3;
    e.rd_en = 1'b0; e.wr_en = 1'b0; e.nomem = 1'b1; e.flush = 1'b0; e.chk_val = 1'b1;
    sa = a;
    sb = b;
    case (op)
      OPREG, OPIMM: begin
        y  = (op == OPREG) ? b : imm;
        sb = y;
        if (op == OPREG && f7 == MD7) begin
          case (f3)
            3'd0: e.value = a * b;
            3'd1: begin p = longint'(sa) * longint'(sb); e.value = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'(b); e.value = p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; e.value = pu[63:32]; end
            3'd4: if (b == 0) e.value = '1;
                  else if (a == 32'h8000_0000 && b == '1) e.value = a;
                  else e.value = sa / sb;
            3'd5: if (b == 0) e.value = '1; else e.value = a / b;
            3'd6: if (b == 0) e.value = a;
                  else if (a == 32'h8000_0000 && b == '1) e.value = '0;
                  else e.value = sa % sb;
            default: if (b == 0) e.value = a; else e.value = a % b;
          endcase
        end else begin
          case (f3)
            3'd0: e.value = (op == OPREG && f7[5]) ? a - y : a + y;
            3'd1: e.value = a << y[4:0];
            3'd2: e.value = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: e.value = (a < y) ? 32'd1 : 32'd0;
            3'd4: e.value = a ^ y;
            3'd5: if (f7[5]) e.value = sa >>> y[4:0]; else e.value = a >> y[4:0];
            3'd6: e.value = a | y;
            default: e.value = a & y;
          endcase
        end
      end
      LUI:   e.value = imm << 12;
      AUIPC: e.value = pc + (imm << 12);
      JAL:   begin e.value = pc + 4; e.flush = 1'b1; end
      JALR:  begin e.value = pc + 4; e.flush = 1'b1; e.target = (a + imm) & 32'hFFFF_FFFE; end
      BR: begin
        e.rd = '0;
        e.chk_val = 1'b0;
        case (f3)
          3'd0: e.flush = (a == b);
          3'd1: e.flush = (a != b);
          3'd4: e.flush = (sa < sb);
          3'd5: e.flush = (sa >= sb);
          3'd6: e.flush = (a < b);
          3'd7: e.flush = (a >= b);
          default: e.flush = 1'b0;
        endcase
      end
      LD: begin e.rd_en = 1'b1; e.nomem = 1'b0; e.addr = a + imm; e.chk_val = 1'b0; end
      ST: begin e.wr_en = 1'b1; e.nomem = 1'b0; e.addr = a + imm; e.value = b; e.rd = '0; end
      default: e.rd = '0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rdOut", 32'(rdOut), 32'(mon_e.rd));
        check("noMEMOut", 32'(noMEMOut), 32'(mon_e.nomem));
        check("readOut", 32'(readOut), 32'(mon_e.rd_en));
        check("writeOut", 32'(writeOut), 32'(mon_e.wr_en));
        if (mon_e.chk_val) check("valueOut", valueOut, mon_e.value);
        if (mon_e.rd_en || mon_e.wr_en) begin
          check("addressOut", addressOut, mon_e.addr);
          check("addressModeOut", 32'(addressModeOut), 32'(mon_e.amode));
        end
      end
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] r, input bit push);
    int unsigned n = 0;
    opcode = op; func3 = f3; func7 = f7; reg1Value = a; reg2Value = b;
    immediate = imm; PC = pc; rd = r; inValid = 1'b1;
    @(negedge clk);
    while (!inReady && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!inReady) begin
      check("accept_timeout", 32'd0, 32'd1);
      inValid = 1'b0;
      return;
    end
    if (push) sb_q.push_back(model(op, f3, f7, a, b, imm, pc, r));
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Called #1 after the accept edge; latency 1 means valid right after that edge.
  task automatic wait_valid(input string tag, input int unsigned exp_lat, input int unsigned exp_busy);
    int unsigned n = 1;
    int unsigned busy = 0;
    while (!outValid && n < 100) begin
      if (!inReady) busy++;
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_lat);
    check({tag, "_inready_low"}, busy, exp_busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; killIn = 1'b0; inValid = 1'b0; outReady = 1'b1;
    opcode = '0; func3 = '0; func7 = '0; reg1Value = '0; reg2Value = '0;
    immediate = '0; PC = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_noMEM", 32'(noMEMOut), 32'd1);
    check("rst_flush", 32'(flushOut), 32'd0);
    check("rst_rw", 32'({readOut, writeOut}), 32'd0);
    check("rst_value", valueOut, 32'd0);
    check("rst_inReady", 32'(inReady), 32'd1);

    // ADD, latency 1
    issue(OPREG, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 32'h0, 5'd3, 1'b1);
    wait_valid("add_latency", 1, 0);

    // MULHU / MULH, iterative latency
    issue(OPREG, 3'd3, MD7, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0, 5'd4, 1'b1);
    wait_valid("mulhu_latency", 33, 32);
    issue(OPREG, 3'd1, MD7, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0, 5'd5, 1'b1);
    wait_valid("mulh_latency", 33, 32);

    // Divide corner cases
    issue(OPREG, 3'd5, MD7, 32'd10, 32'd0, 32'd0, 32'h0, 5'd6, 1'b1);
    wait_valid("divu0_latency", 1, 0);
    issue(OPREG, 3'd6, MD7, 32'd10, 32'd0, 32'd0, 32'h0, 5'd7, 1'b1);
    issue(OPREG, 3'd4, MD7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0, 5'd8, 1'b1);
    wait_valid("div_ovf_latency", 1, 0);
    issue(OPREG, 3'd6, MD7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0, 5'd8, 1'b1);
    issue(OPREG, 3'd4, MD7, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h0, 5'd9, 1'b1);
    wait_valid("div_latency", 33, 32);
    issue(OPREG, 3'd6, MD7, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h0, 5'd9, 1'b1);

    // Branches and jumps
    issue(BR, 3'd0, 7'h00, 32'd9, 32'd9, 32'h20, 32'h100, 5'd1, 1'b1);
    check("beq_flush", 32'(flushOut), 32'd1);
    check("beq_target", flushAddrOut, 32'h120);
    @(posedge clk); #1;
    check("beq_flush_one_cycle", 32'(flushOut), 32'd0);
    issue(BR, 3'd1, 7'h00, 32'd9, 32'd9, 32'h20, 32'h100, 5'd1, 1'b1);
    check("bne_flush", 32'(flushOut), 32'd0);
    issue(BR, 3'd2, 7'h00, 32'd1, 32'd2, 32'h20, 32'h100, 5'd1, 1'b1);
    check("br_bad_f3_flush", 32'(flushOut), 32'd0);
    issue(BR, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 5'd1, 1'b1);
    check("blt_flush", 32'(flushOut), 32'd1);
    issue(BR, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 5'd1, 1'b1);
    check("bltu_flush", 32'(flushOut), 32'd0);
    issue(JALR, 3'd0, 7'h00, 32'h201, 32'd0, 32'd0, 32'h300, 5'd1, 1'b1);
    check("jalr_flush", 32'(flushOut), 32'd1);
    check("jalr_target", flushAddrOut, 32'h200);

    // Other single-cycle classes
    issue(LUI, 3'd0, 7'h00, 32'd0, 32'd0, 32'h12345, 32'h0, 5'd10, 1'b1);
    issue(AUIPC, 3'd0, 7'h00, 32'd0, 32'd0, 32'h1, 32'h400, 5'd11, 1'b1);
    issue(LD, 3'd2, 7'h00, 32'hFFFF_FFF0, 32'd0, 32'h20, 32'h0, 5'd12, 1'b1);
    issue(ST, 3'd1, 7'h00, 32'h1000, 32'hCAFE_BABE, 32'hFFFF_FFFC, 32'h0, 5'd13, 1'b1);
    issue(7'b1111111, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 32'h0, 5'd14, 1'b1);

    // JAL held by backpressure
    @(posedge clk); #1;
    outReady = 1'b0;
    issue(JAL, 3'd0, 7'h00, 32'd0, 32'd0, 32'h40, 32'h500, 5'd1, 1'b1);
    check("jal_flush", 32'(flushOut), 32'd1);
    check("jal_target", flushAddrOut, 32'h540);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("jal_hold_flush", 32'(flushOut), 32'd0);
      check("jal_hold_value", valueOut, 32'h504);
      check("jal_hold_valid", 32'(outValid), 32'd1);
      check("jal_hold_inready", 32'(inReady), 32'd0);
    end
    outReady = 1'b1;

    // Kill and reset in the middle of a divide
    issue(OPREG, 3'd4, MD7, 32'd100, 32'd7, 32'd0, 32'h0, 5'd15, 1'b0);
    repeat (9) @(posedge clk);
    #1 killIn = 1'b1;
    @(posedge clk); #1 killIn = 1'b0;
    check("kill_outValid", 32'(outValid), 32'd0);
    check("kill_inReady", 32'(inReady), 32'd1);
    issue(OPREG, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0, 32'h0, 5'd16, 1'b1);
    wait_valid("post_kill_add", 1, 0);
    issue(OPREG, 3'd5, MD7, 32'd100, 32'd7, 32'd0, 32'h0, 5'd17, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst2_outValid", 32'(outValid), 32'd0);
    check("rst2_noMEM", 32'(noMEMOut), 32'd1);
    check("rst2_inReady", 32'(inReady), 32'd1);
    issue(OPREG, 3'd0, 7'h20, 32'd1, 32'd2, 32'd0, 32'h0, 5'd18, 1'b1);
    wait_valid("post_rst_sub", 1, 0);

    // Random ALU and MD traffic
    for (int i = 0; i < 40; i++) begin
      issue(($urandom_range(0, 1) != 0) ? OPIMM : OPREG, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, $urandom, $urandom, $urandom,
            32'h0, 5'($urandom_range(1, 31)), 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      issue(OPREG, 3'($urandom_range(0, 7)), MD7, $urandom,
            (i % 4 == 0) ? 32'd0 : (i % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom,
            32'd0, 32'h0, 5'($urandom_range(1, 31)), 1'b1);
    end

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
